conv_scheduler: RTL

CONV_SCHEDULER -- requirements
Module: conv_scheduler

---
 rtl/conv_pkg.sv | 18 +
 rtl/conv_pos_counter.sv | 40 ++++
 rtl/conv_scheduler.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution window scheduler.
package conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRIME  = 3'd1,
        ST_STREAM = 3'd2,
        ST_HOLD   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int PRIME_CNT   = 9;
    localparam int STREAM_CNT  = 3;
    localparam int KERNEL_SIZE = 3;
    localparam int KERNEL_NB   = 8;
    localparam int KERNEL_TAPS = KERNEL_SIZE * KERNEL_SIZE;

endpackage

// File: rtl/conv_pos_counter.sv
// Nested column/row position of the current window; col runs fastest.
// Flags mark the last window column of a strip and the last strip of a frame.
module conv_pos_counter #(
    parameter int IMG_W_NB = 10,
    parameter int IMG_H_NB = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                step,
    input  logic [IMG_W_NB-1:0] width,
    input  logic [IMG_H_NB-1:0] height,
    output logic                last_col,
    output logic                last_row
);
    import conv_pkg::*;

    logic [IMG_W_NB-1:0] col;
    logic [IMG_H_NB-1:0] row;

    // Window origin runs 0..dim-3, so the last one sits KERNEL_SIZE from the edge.
    assign last_col = (col == width  - IMG_W_NB'(KERNEL_SIZE));
    assign last_row = (row == height - IMG_H_NB'(KERNEL_SIZE));

    // Advance along the strip, then wrap to the next strip.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            col <= '0;
            row <= '0;
        end else if (step) begin
            if (!last_col) begin
                col <= col + IMG_W_NB'(1);
            end else if (!last_row) begin
                col <= '0;
                row <= row + IMG_H_NB'(1);
            end
        end
    end

endmodule

// File: rtl/conv_scheduler.sv
// Frame scheduler for a 3x3 convolution datapath: primes each strip with a
// full window, streams one column per window, and holds each result until
// downstream accepts it.
//
// state  | meaning
// IDLE   | waiting for cfg_start; kernel coefficient writes accepted
// PRIME  | filling the 9-pixel window at the start of a strip
// STREAM | shifting in the 3 pixels of the next column
// HOLD   | window result valid, waiting for m_tready
// DONE   | one-cycle end-of-frame pulse
module conv_scheduler #(
    parameter int IMG_W_NB    = 10,
    parameter int IMG_H_NB    = 10,
    parameter int KERNEL_NB   = 8,
    parameter int KERNEL_SIZE = 3
) (
    input  logic                 axis_aclk,
    input  logic                 axis_rst,
    input  logic                 cfg_start,
    input  logic [IMG_W_NB-1:0]  cfg_width,
    input  logic [IMG_H_NB-1:0]  cfg_height,
    input  logic                 cfg_kernel_wr,
    input  logic [3:0]           cfg_kernel_addr,
    input  logic [KERNEL_NB-1:0] cfg_kernel_data,
    output logic                 kernel_we,
    output logic [3:0]           kernel_addr,
    output logic [KERNEL_NB-1:0] kernel_data,
    input  logic                 s_tvalid,
    output logic                 s_tready,
    output logic                 dp_shift_en,
    output logic                 dp_prime,
    output logic                 dp_out_valid,
    input  logic                 m_tready,
    output logic                 dp_out_last,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_err
);
    import conv_pkg::*;

    state_t              state, state_nxt;
    logic [IMG_W_NB-1:0] width_q;
    logic [IMG_H_NB-1:0] height_q;
    logic [3:0]          pix_cnt;
    logic                start_ok, start_bad, pix_last, pos_step;
    logic                last_col, last_row;

    assign start_ok  = (state == ST_IDLE) && cfg_start &&
                       (cfg_width  >= IMG_W_NB'(KERNEL_SIZE)) &&
                       (cfg_height >= IMG_H_NB'(KERNEL_SIZE));
    assign start_bad = (state == ST_IDLE) && cfg_start && !start_ok;

    assign dp_shift_en = s_tvalid & s_tready;
    assign pix_last    = dp_shift_en &&
                         (pix_cnt == ((state == ST_PRIME) ? 4'(PRIME_CNT - 1)
                                                          : 4'(STREAM_CNT - 1)));

    // State register.
    always_ff @(posedge axis_aclk) begin
        if (axis_rst) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Next-state and per-state outputs.
    always_comb begin
        state_nxt    = state;
        s_tready     = 1'b0;
        dp_prime     = 1'b0;
        dp_out_valid = 1'b0;
        dp_out_last  = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        pos_step     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_ok) state_nxt = ST_PRIME;
            end
            ST_PRIME: begin
                s_tready = 1'b1;
                dp_prime = 1'b1;
                busy     = 1'b1;
                if (pix_last) state_nxt = ST_HOLD;
            end
            ST_STREAM: begin
                s_tready = 1'b1;
                busy     = 1'b1;
                if (pix_last) state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                busy         = 1'b1;
                dp_out_valid = 1'b1;
                dp_out_last  = last_col && last_row;
                if (m_tready) begin
                    if (!last_col) begin
                        pos_step  = 1'b1;
                        state_nxt = ST_STREAM;
                    end else if (!last_row) begin
                        pos_step  = 1'b1;
                        state_nxt = ST_PRIME;
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Pixels accepted in the current PRIME/STREAM phase; cleared by the completing accept.
    always_ff @(posedge axis_aclk) begin
        if (axis_rst || start_ok) pix_cnt <= '0;
        else if (dp_shift_en)     pix_cnt <= pix_last ? 4'd0 : pix_cnt + 4'd1;
    end

    // Frame geometry captured at a valid start.
    always_ff @(posedge axis_aclk) begin
        if (axis_rst) begin
            width_q  <= '0;
            height_q <= '0;
        end else if (start_ok) begin
            width_q  <= cfg_width;
            height_q <= cfg_height;
        end
    end

    // Bad-config pulse and registered coefficient forwarding (IDLE only).
    always_ff @(posedge axis_aclk) begin
        if (axis_rst) begin
            cfg_err     <= 1'b0;
            kernel_we   <= 1'b0;
            kernel_addr <= '0;
            kernel_data <= '0;
        end else begin
            cfg_err   <= start_bad;
            kernel_we <= (state == ST_IDLE) && cfg_kernel_wr &&
                         (cfg_kernel_addr <= 4'(KERNEL_TAPS - 1));
            if ((state == ST_IDLE) && cfg_kernel_wr) begin
                kernel_addr <= cfg_kernel_addr;
                kernel_data <= cfg_kernel_data;
            end
        end
    end

    conv_pos_counter #(
        .IMG_W_NB (IMG_W_NB),
        .IMG_H_NB (IMG_H_NB)
    ) u_pos (
        .clk      (axis_aclk),
        .rst      (axis_rst),
        .clear    (start_ok),
        .step     (pos_step),
        .width    (width_q),
        .height   (height_q),
        .last_col (last_col),
        .last_row (last_row)
    );

endmodule
